// File: rtl/stat_pkg.sv
// Shared types and sizes for the statistics readout path.
// Counter width here must match the statistics block that produces J/R/I/TotalCycles.
package stat_pkg;

    localparam int STAT_WORDS  = 4;
    localparam int STAT_BYTES  = 16;
    localparam int STAT_WORD_W = 32;
    localparam int STAT_SNAP_W = STAT_WORDS * STAT_WORD_W;
    localparam int STAT_IDX_W  = $clog2(STAT_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } stat_state_e;

endpackage

// File: rtl/stat_byte_sel.sv
// Combinational byte picker: byte k of the snapshot is bits 8k+7:8k,
// so packing the words as {TotalCycles, I, R, J} yields J first, LSB first.
module stat_byte_sel
    import stat_pkg::*;
(
    input  logic [STAT_SNAP_W-1:0] snap,
    input  logic [STAT_IDX_W-1:0]  idx,
    output logic [7:0]             sel_byte
);

    logic [7:0] snap_bytes [STAT_BYTES];

    for (genvar gi = 0; gi < STAT_BYTES; gi++) begin : g_byte
        assign snap_bytes[gi] = snap[8*gi +: 8];
    end

    assign sel_byte = snap_bytes[idx];

endmodule

// File: rtl/stat_readout.sv
// Snapshot-and-stream reader for the instruction statistics counters.
// Define STAT_READOUT_CSUM_EN to append a modulo-256 checksum byte after the 16 data bytes.
module stat_readout
    import stat_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [STAT_WORD_W-1:0] J,
    input  logic [STAT_WORD_W-1:0] R,
    input  logic [STAT_WORD_W-1:0] I,
    input  logic [STAT_WORD_W-1:0] TotalCycles,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [STAT_IDX_W-1:0] LAST_IDX = STAT_IDX_W'(STAT_BYTES - 1);

    stat_state_e            state_q, state_d;
    logic [STAT_SNAP_W-1:0] snap_q, snap_d;
    logic [STAT_IDX_W-1:0]  idx_q, idx_d;
    logic                   done_q, done_d;
    logic [7:0]             sel_byte;
    logic                   hs;
`ifdef STAT_READOUT_CSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    stat_byte_sel u_sel (
        .snap     (snap_q),
        .idx      (idx_q),
        .sel_byte (sel_byte)
    );

    assign hs = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef STAT_READOUT_CSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    snap_d  = {TotalCycles, I, R, J};
                    idx_d   = '0;
`ifdef STAT_READOUT_CSUM_EN
                    sum_d   = '0;
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
`ifdef STAT_READOUT_CSUM_EN
                    sum_d = sum_q + sel_byte;
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef STAT_READOUT_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef STAT_READOUT_CSUM_EN
            CSUM: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef STAT_READOUT_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
`ifdef STAT_READOUT_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Outputs decode straight from the state flop, so reset clears them asynchronously.
    always_comb begin
        out_data = 8'h00;
        if (state_q == SEND) begin
            out_data = sel_byte;
        end
`ifdef STAT_READOUT_CSUM_EN
        else if (state_q == CSUM) begin
            out_data = sum_q;
        end
`endif
    end

    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
